// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program-counter unit with next-PC select and return-address stack
//
// Holds the fetch PC and computes its successor: sequential increment,
// PC-relative branch, absolute jump, call (push PC+INC) and return (pop).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   ena       advance enable; low holds all state
//   mode      next-PC select: 0 seq, 1 branch, 2 jump, 3 call, 4 return, 5-7 seq
//   data_in   absolute target for jump/call
//   offset    signed byte offset for branch (pre-shifted, sign-extended)
//   data_out  current PC (registered)
//   pc_plus   data_out + INC (combinational)
//   ras_count number of valid return-address entries
//   ras_full  ras_count == RAS_DEPTH
//   ras_empty ras_count == 0
//   ras_ovf   sticky: call while stack full
//   ras_unf   sticky: return while stack empty

module pc_unit #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(32'h0040_0000),
    parameter int                INC          = 4,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [2:0]                     mode,
    input  logic [WIDTH-1:0]               data_in,
    input  logic [WIDTH-1:0]               offset,
    output logic [WIDTH-1:0]               data_out,
    output logic [WIDTH-1:0]               pc_plus,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_full,
    output logic                           ras_empty,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);
    localparam logic [CW-1:0]    ONE_C   = CW'(1);
    localparam logic [PW-1:0]    ONE_P   = PW'(1);

    localparam logic [2:0] MODE_SEQ    = 3'd0;
    localparam logic [2:0] MODE_BRANCH = 3'd1;
    localparam logic [2:0] MODE_JUMP   = 3'd2;
    localparam logic [2:0] MODE_CALL   = 3'd3;
    localparam logic [2:0] MODE_RET    = 3'd4;

    // ras_ptr indexes the current top entry. A push writes one slot above it,
    // so when the stack is full the write lands on the oldest entry, which is
    // exactly the overwrite-oldest behaviour wanted on overflow.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [PW-1:0]    ptr_up;
    logic [PW-1:0]    ptr_down;

    logic [WIDTH-1:0] pc_next;
    logic             do_push;
    logic             do_pop;
    logic             set_unf;

    assign pc_plus   = data_out + INC_W;
    assign ras_full  = (ras_count == DEPTH_C);
    assign ras_empty = (ras_count == '0);
    assign ptr_up    = ras_ptr + ONE_P;
    assign ptr_down  = ras_ptr - ONE_P;

    always_comb begin
        pc_next = pc_plus;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_unf = 1'b0;
        case (mode)
            MODE_SEQ:    pc_next = pc_plus;
            MODE_BRANCH: pc_next = pc_plus + offset;
            MODE_JUMP:   pc_next = data_in;
            MODE_CALL: begin
                pc_next = data_in;
                do_push = 1'b1;
            end
            MODE_RET: begin
                // Return on an empty stack degrades to a sequential step.
                if (ras_empty) begin
                    pc_next = pc_plus;
                    set_unf = 1'b1;
                end else begin
                    pc_next = ras_mem[ras_ptr];
                    do_pop  = 1'b1;
                end
            end
            default:     pc_next = pc_plus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out  <= RESET_VECTOR;
            ras_ptr   <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else if (ena) begin
            data_out <= pc_next;
            if (do_push) begin
                ras_mem[ptr_up] <= pc_plus;
                ras_ptr         <= ptr_up;
                if (ras_full) begin
                    ras_ovf <= 1'b1;
                end else begin
                    ras_count <= ras_count + ONE_C;
                end
            end
            if (do_pop) begin
                ras_ptr   <= ptr_down;
                ras_count <= ras_count - ONE_C;
            end
            if (set_unf) begin
                ras_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit

module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [2:0]  mode;
    logic [31:0] data_in;
    logic [31:0] offset;
    logic [31:0] data_out;
    logic [31:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ras_full;
    logic        ras_empty;
    logic        ras_ovf;
    logic        ras_unf;

    int checks   = 0;
    int failures = 0;

    pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .mode      (mode),
        .data_in   (data_in),
        .offset    (offset),
        .data_out  (data_out),
        .pc_plus   (pc_plus),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle outputs away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic op(input logic [2:0] m, input logic [31:0] d, input logic [31:0] o);
        mode    = m;
        data_in = d;
        offset  = o;
        step();
    endtask

    logic [31:0] tgt [5];

    initial begin
        rst     = 1'b0;
        ena     = 1'b0;
        mode    = 3'd0;
        data_in = '0;
        offset  = '0;

        // 1: reset state and sequential stepping
        step();
        step();
        check_eq("rst_pc",    data_out,  32'h0040_0000);
        check_eq("rst_plus",  pc_plus,   32'h0040_0004);
        check_eq("rst_cnt",   ras_count, 32'd0);
        check_eq("rst_empty", ras_empty, 32'd1);
        check_eq("rst_full",  ras_full,  32'd0);
        check_eq("rst_ovf",   ras_ovf,   32'd0);
        check_eq("rst_unf",   ras_unf,   32'd0);
        rst = 1'b1;
        ena = 1'b1;
        op(3'd0, '0, '0); check_eq("seq1", data_out, 32'h0040_0004);
        op(3'd0, '0, '0); check_eq("seq2", data_out, 32'h0040_0008);
        op(3'd0, '0, '0); check_eq("seq3", data_out, 32'h0040_000C);
        check_eq("seq_empty", ras_empty, 32'd1);
        rst = 1'b0;
        op(3'd2, 32'hDEAD_BEEF, '0);
        check_eq("mid_rst", data_out, 32'h0040_0000);
        rst = 1'b1;

        // 2: branch back, hold while disabled, then jump
        repeat (4) op(3'd0, '0, '0);
        check_eq("pre_br", data_out, 32'h0040_0010);
        op(3'd1, '0, 32'hFFFF_FFF0);
        check_eq("branch_neg", data_out, 32'h0040_0004);
        ena = 1'b0;
        repeat (3) op(3'd2, 32'h1234_5678, '0);
        check_eq("hold_pc", data_out, 32'h0040_0004);
        ena = 1'b1;
        op(3'd2, 32'h1234_5678, '0);
        check_eq("jump", data_out, 32'h1234_5678);
        op(3'd1, '0, 32'h0000_0100);
        check_eq("branch_pos", data_out, 32'h1234_577C);

        // 3: nested call/return, back-to-back
        do_reset();
        op(3'd3, 32'h0040_1000, '0);
        check_eq("call1_pc", data_out, 32'h0040_1000);
        check_eq("call1_cnt", ras_count, 32'd1);
        op(3'd3, 32'h0040_2000, '0);
        check_eq("call2_pc", data_out, 32'h0040_2000);
        check_eq("call2_cnt", ras_count, 32'd2);
        ena = 1'b0;
        op(3'd4, '0, '0);
        check_eq("hold_cnt", ras_count, 32'd2);
        ena = 1'b1;
        op(3'd4, '0, '0);
        check_eq("ret1_pc", data_out, 32'h0040_1004);
        check_eq("ret1_cnt", ras_count, 32'd1);
        op(3'd4, '0, '0);
        check_eq("ret2_pc", data_out, 32'h0040_0004);
        check_eq("ret2_cnt", ras_count, 32'd0);
        check_eq("ret2_empty", ras_empty, 32'd1);

        // 4: overflow drops the oldest entry
        do_reset();
        for (int i = 0; i < 5; i++) tgt[i] = 32'h0050_0000 + 32'(i) * 32'h100;
        for (int i = 0; i < 4; i++) op(3'd3, tgt[i], '0);
        check_eq("fill_cnt", ras_count, 32'd4);
        check_eq("fill_full", ras_full, 32'd1);
        check_eq("fill_ovf", ras_ovf, 32'd0);
        op(3'd3, tgt[4], '0);
        check_eq("ovf_flag", ras_ovf, 32'd1);
        check_eq("ovf_cnt", ras_count, 32'd4);
        check_eq("ovf_full", ras_full, 32'd1);
        check_eq("ovf_pc", data_out, tgt[4]);
        for (int i = 3; i >= 0; i--) begin
            op(3'd4, '0, '0);
            check_eq($sformatf("ovf_ret%0d", i), data_out, tgt[i] + 32'd4);
            check_eq($sformatf("ovf_cnt%0d", i), ras_count, 32'(i));
        end
        op(3'd4, '0, '0);
        check_eq("lost_entry_pc", data_out, tgt[0] + 32'd8);
        check_eq("lost_entry_unf", ras_unf, 32'd1);
        check_eq("ovf_sticky", ras_ovf, 32'd1);

        // 5: underflow from reset, sticky until reset
        do_reset();
        check_eq("ovf_cleared", ras_ovf, 32'd0);
        op(3'd4, '0, '0);
        check_eq("unf_pc", data_out, 32'h0040_0004);
        check_eq("unf_flag", ras_unf, 32'd1);
        check_eq("unf_cnt", ras_count, 32'd0);
        repeat (10) op(3'd0, '0, '0);
        check_eq("unf_sticky", ras_unf, 32'd1);
        check_eq("unf_seq_pc", data_out, 32'h0040_002C);
        op(3'd3, 32'h0060_0000, '0);
        op(3'd4, '0, '0);
        check_eq("after_unf_ret", data_out, 32'h0040_0030);
        do_reset();
        check_eq("unf_cleared", ras_unf, 32'd0);

        // 6: wraparound and unused mode encodings
        op(3'd2, 32'hFFFF_FFFC, '0);
        check_eq("wrap_plus", pc_plus, 32'h0000_0000);
        op(3'd0, '0, '0);
        check_eq("wrap_seq", data_out, 32'h0000_0000);
        op(3'd7, 32'h1111_1111, 32'h2222_2222);
        check_eq("mode7", data_out, 32'h0000_0004);
        op(3'd5, 32'h1111_1111, 32'h2222_2222);
        check_eq("mode5", data_out, 32'h0000_0008);
        op(3'd6, 32'h1111_1111, 32'h2222_2222);
        check_eq("mode6", data_out, 32'h0000_000C);
        check_eq("mode6_cnt", ras_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
